mem_bus_responder: RTL

//  Memory-side responder of the shared register/data bus: services read_q/write_q requests

---
 rtl/mem_bus_responder_if.sv | 38 +++
 rtl/mem_bus_responder.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mem_bus_responder_if.sv
// Shared register/data bus between the per-operand register managers (master)
// and the memory-side responder (slave). addr/data/is_bus_busy are tri-state
// nets shared by every party on the bus.
interface mem_bus_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              read_q;
  logic              write_q;
  wire  [ADDR_W-1:0] addr;
  wire  [DATA_W-1:0] data;
  wire               is_bus_busy;
  logic              read_dn;
  logic              write_dn;
  logic              req_dropped;

  modport slave (
    input  read_q,
    input  write_q,
    inout  addr,
    inout  data,
    inout  is_bus_busy,
    output read_dn,
    output write_dn,
    output req_dropped
  );

  modport master (
    output read_q,
    output write_q,
    inout  addr,
    inout  data,
    inout  is_bus_busy,
    input  read_dn,
    input  write_dn,
    input  req_dropped
  );
endinterface

// File: rtl/mem_bus_responder.sv
// Memory-side responder: accepts one read/write request at a time from the
// shared bus, services it against a local word RAM after a fixed latency and
// echoes addr + data in a single DONE cycle with a read_dn/write_dn strobe.
// A read arriving together with a write is held and chained right after the
// write without releasing is_bus_busy.
module mem_bus_responder #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 256,
  parameter int RD_LAT    = 2,
  parameter int WR_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_bus_responder_if.slave   bus
);

  localparam int IDX_W   = $clog2(MEM_DEPTH);
  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               op_wr, op_wr_nxt;
  logic               pend_v, pend_v_nxt;
  logic               req_dropped_q;

  logic               ld_req;
  logic               ld_pend;
  logic               ld_from_pend;
  logic               mem_access;

  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  pend_addr;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  done_data;
  logic [DATA_W-1:0]  mem [MEM_DEPTH];

  logic               rd_req;
  logic               wr_req;
  logic [IDX_W-1:0]   idx;

  // Undriven (z) request lines count as no request.
  assign rd_req = (bus.read_q === 1'b1);
  assign wr_req = (bus.write_q === 1'b1);
  assign idx    = addr_q[IDX_W-1:0];

  // FSM state and control registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      op_wr         <= 1'b0;
      pend_v        <= 1'b0;
      req_dropped_q <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      op_wr         <= op_wr_nxt;
      pend_v        <= pend_v_nxt;
      req_dropped_q <= (state != IDLE) && (rd_req || wr_req);
    end
  end

  // Next-state decode and load enables for the bus-side data registers.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    op_wr_nxt    = op_wr;
    pend_v_nxt   = pend_v;
    ld_req       = 1'b0;
    ld_pend      = 1'b0;
    ld_from_pend = 1'b0;
    mem_access   = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req) begin
          state_nxt = WAIT;
          op_wr_nxt = 1'b1;
          cnt_nxt   = CNT_W'(WR_LAT - 1);
          ld_req    = 1'b1;
          if (rd_req) begin
            pend_v_nxt = 1'b1;
            ld_pend    = 1'b1;
          end
        end else if (rd_req) begin
          state_nxt = WAIT;
          op_wr_nxt = 1'b0;
          cnt_nxt   = CNT_W'(RD_LAT - 1);
          ld_req    = 1'b1;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt  = DONE;
          mem_access = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      DONE: begin
        if (pend_v) begin
          state_nxt    = WAIT;
          op_wr_nxt    = 1'b0;
          pend_v_nxt   = 1'b0;
          cnt_nxt      = CNT_W'(RD_LAT - 1);
          ld_from_pend = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request address/data capture; the pending read shares the write's addr.
  always_ff @(posedge clk) begin
    if (ld_req) begin
      addr_q  <= bus.addr;
      wdata_q <= bus.data;
    end
    if (ld_pend) begin
      pend_addr <= bus.addr;
    end
    if (ld_from_pend) begin
      addr_q <= pend_addr;
    end
  end

  // RAM access on DONE entry; a write cut off by reset never lands.
  always_ff @(posedge clk) begin
    if (mem_access && !rst) begin
      if (op_wr) begin
        mem[idx]  <= wdata_q;
        done_data <= wdata_q;
      end else begin
        done_data <= mem[idx];
      end
    end
  end

  assign bus.is_bus_busy = (state != IDLE) ? 1'b1 : 1'bz;
  assign bus.addr        = (state == DONE) ? addr_q : {ADDR_W{1'bz}};
  assign bus.data        = (state == DONE) ? done_data : {DATA_W{1'bz}};
  assign bus.read_dn     = (state == DONE) && !op_wr;
  assign bus.write_dn    = (state == DONE) && op_wr;
  assign bus.req_dropped = req_dropped_q;

endmodule
